instr_register_calc: RTL and testbench

Parametrised successor to the instruction register. A DEPTH-entry register file stores an opcode and two signed operands, and computes and stores the result at write time. Each entry carries a valid bit. The block keeps an occupancy count and returns the addressed entry on a registered read port. It sits between the testbench interface (driven on test_clk) and the checker, clocked by the design clock.

---
 rtl/instr_register_calc_pkg.sv | 35 +++
 rtl/instr_register_calc_if.sv | 33 +++
 rtl/instr_register_calc_calc.sv | 43 ++++
 rtl/instr_register_calc.sv | 114 +++++++++++
 tb/tb_instr_register_calc.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_calc_pkg.sv
// Shared types for the calculating instruction register: opcode encoding,
// operand/result types and the packed instruction word. OPERAND_W here is
// the default operand width used by the packed types.
package instr_register_pkg;

  localparam int OPERAND_W = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0]   operand_t;
  typedef logic signed [2*OPERAND_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t a;
    operand_t b;
    result_t  result;
    logic     div0;
  } instruction_t;

  // Even parity bit: XOR of every bit, so word plus bit has an even count of ones.
  function automatic logic parity_of(input instruction_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/instr_register_calc_if.sv
// Bus between the stimulus side (master) and the register file (slave).
// No handshake: load_en is a one-cycle write strobe; read_pointer is
// sampled every cycle and the read data is returned one cycle later.
interface instr_register_calc_if
  import instr_register_pkg::*;
#(
  parameter int OPERAND_W = instr_register_pkg::OPERAND_W,
  parameter int DEPTH     = 32,
  parameter int PTR_W     = $clog2(DEPTH)
);

  logic                        load_en;
  opcode_t                     opcode;
  logic signed [OPERAND_W-1:0] operand_a;
  logic signed [OPERAND_W-1:0] operand_b;
  logic [PTR_W-1:0]            write_pointer;
  logic [PTR_W-1:0]            read_pointer;
  instruction_t                instruction_word;
  logic                        read_valid;
  logic [PTR_W:0]              count;
  logic                        parity_err;

  modport master (
    output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    input  instruction_word, read_valid, count, parity_err
  );

  modport slave (
    input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    output instruction_word, read_valid, count, parity_err
  );

endinterface

// File: rtl/instr_register_calc_calc.sv
// instr_calc: combinational ALU evaluated at write time. Operands are
// sign-extended to result width first so MULT keeps the full product and
// DIV of the most negative value by -1 does not overflow.
module instr_calc
  import instr_register_pkg::*;
(
  input  opcode_t  i_opcode,
  input  operand_t i_a,
  input  operand_t i_b,
  output result_t  o_result,
  output logic     o_div0
);

  result_t w_a_ext;
  result_t w_b_ext;

  assign w_a_ext = {{OPERAND_W{i_a[OPERAND_W-1]}}, i_a};
  assign w_b_ext = {{OPERAND_W{i_b[OPERAND_W-1]}}, i_b};

  // Result selection; divide/modulo by zero yields 0 and flags div0.
  always_comb begin
    o_result = '0;
    o_div0   = 1'b0;
    case (i_opcode)
      ZERO:  o_result = '0;
      PASSA: o_result = w_a_ext;
      PASSB: o_result = w_b_ext;
      ADD:   o_result = w_a_ext + w_b_ext;
      SUB:   o_result = w_a_ext - w_b_ext;
      MULT:  o_result = w_a_ext * w_b_ext;
      DIV: begin
        if (i_b == '0) o_div0   = 1'b1;
        else           o_result = w_a_ext / w_b_ext;
      end
      MOD: begin
        if (i_b == '0) o_div0   = 1'b1;
        else           o_result = w_a_ext % w_b_ext;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_calc.sv
// instr_register_calc: DEPTH-entry instruction register file that stores
// {opcode, a, b, result, div0} with a valid bit, keeps an occupancy count
// and returns the addressed entry on a registered, write-first read port.
// Optional feature macro: INSTR_REGISTER_PARITY_EN (per-entry even parity,
// checked on read; parity_err tied to 0 when undefined).
module instr_register_calc
  import instr_register_pkg::*;
#(
  parameter int OPERAND_W = instr_register_pkg::OPERAND_W,
  parameter int DEPTH     = 32,
  localparam int PTR_W    = $clog2(DEPTH)
)(
  input logic                  clk,
  input logic                  reset_n,
  instr_register_calc_if.slave bus
);

  instruction_t     r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W:0]   r_count;
  instruction_t     r_rd_word;
  logic             r_rd_valid;

  logic signed [OPERAND_W-1:0] w_a;
  logic signed [OPERAND_W-1:0] w_b;
  result_t                     w_result;
  logic                        w_div0;
  instruction_t                w_new;
  logic                        w_bypass;

  assign w_a = bus.operand_a;
  assign w_b = bus.operand_b;

  instr_calc u_calc (
    .i_opcode (bus.opcode),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  assign w_new = '{opcode: bus.opcode, a: w_a, b: w_b, result: w_result, div0: w_div0};

  // Same-address write and read in one cycle returns the new data.
  assign w_bypass = bus.load_en && (bus.write_pointer == bus.read_pointer);

  // Storage: write the computed entry and mark it valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else if (bus.load_en) begin
      r_mem[bus.write_pointer]   <= w_new;
      r_valid[bus.write_pointer] <= 1'b1;
    end
  end

  // Occupancy: only a write into a previously invalid entry adds one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (bus.load_en && !r_valid[bus.write_pointer]) begin
      r_count <= r_count + (PTR_W+1)'(1);
    end
  end

  // Registered read port with write-first bypass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_word  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_bypass) begin
      r_rd_word  <= w_new;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_word  <= r_mem[bus.read_pointer];
      r_rd_valid <= r_valid[bus.read_pointer];
    end
  end

`ifdef INSTR_REGISTER_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_par_err;

  // Parity store: captured alongside the entry at write time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par <= '0;
    end else if (bus.load_en) begin
      r_par[bus.write_pointer] <= parity_of(w_new);
    end
  end

  // Parity check on read; bypassed data is freshly computed so never errs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_err <= 1'b0;
    end else if (w_bypass) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= parity_of(r_mem[bus.read_pointer]) != r_par[bus.read_pointer];
    end
  end

  assign bus.parity_err = r_par_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.instruction_word = r_rd_word;
  assign bus.read_valid       = r_rd_valid;
  assign bus.count            = r_count;

endmodule

// File: tb/tb_instr_register_calc.sv
// Bench for instr_register_calc: directed scenarios plus randomized traffic
// checked against a behavioural model of the register file.
module tb_instr_register_calc;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = $bits(instruction_t);

  logic clk;
  logic reset_n;

  instr_register_calc_if #(.OPERAND_W(32), .DEPTH(DEPTH)) bus ();

  instr_register_calc #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  logic [3:0] m_op    [DEPTH];
  longint     m_a     [DEPTH];
  longint     m_b     [DEPTH];
  longint     m_res   [DEPTH];
  bit         m_div0  [DEPTH];
  bit         m_valid [DEPTH];

  logic [W-1:0] exp_q[$];
  logic         exp_v_q[$];

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] got_w;
  logic [W-1:0] exp_w;
  logic         exp_v;

  function automatic void ref_calc(input int op, input longint a, input longint b,
                                   output longint res, output bit d0);
    res = 0;
    d0  = 1'b0;
    case (op)
      1: res = a;
      2: res = b;
      3: res = a + b;
      4: res = a - b;
      5: res = a * b;
      6: if (b == 0) d0 = 1'b1; else res = a / b;
      7: if (b == 0) d0 = 1'b1; else res = a % b;
      default: res = 0;
    endcase
  endfunction

  function automatic logic [W-1:0] pack_entry(input logic [3:0] op, input longint a,
                                              input longint b, input longint res, input bit d0);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    r64 = res;
    return {op, a32, b32, r64, d0};
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_op[i] = '0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_div0[i] = 0; m_valid[i] = 0;
    end
  endfunction

  // ---------------- driver ----------------
  // One clock: drive after negedge, update model at posedge, settle #1.
  task automatic step(input bit le, input logic [3:0] op, input longint a, input longint b,
                      input int wp, input int rp);
    longint res;
    bit     d0;
    logic [31:0] a32;
    logic [31:0] b32;
    a32 = a[31:0];
    b32 = b[31:0];
    @(negedge clk);
    bus.load_en       = le;
    bus.opcode        = opcode_t'(op);
    bus.operand_a     = a32;
    bus.operand_b     = b32;
    bus.write_pointer = PTR_W'(wp);
    bus.read_pointer  = PTR_W'(rp);
    @(posedge clk);
    ref_calc(int'(op), longint'($signed(a32)), longint'($signed(b32)), res, d0);
    if (le && wp == rp) begin
      exp_q.push_back(pack_entry(op, a, b, res, d0));
      exp_v_q.push_back(1'b1);
    end else begin
      exp_q.push_back(pack_entry(m_op[rp], m_a[rp], m_b[rp], m_res[rp], m_div0[rp]));
      exp_v_q.push_back(m_valid[rp]);
    end
    if (le) begin
      m_op[wp] = op; m_a[wp] = a; m_b[wp] = b; m_res[wp] = res; m_div0[wp] = d0; m_valid[wp] = 1'b1;
    end
    #1;
  endtask

  function automatic longint rand_operand();
    int x;
    case ($urandom_range(0, 3))
      0: x = 0;
      1: x = int'($urandom_range(0, 40)) - 20;
      2: x = ($urandom_range(0, 1) == 1) ? 32'sh7fffffff : 32'sh80000000;
      default: x = int'($urandom);
    endcase
    return longint'(x);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.load_en = 1'b0; bus.opcode = ZERO; bus.operand_a = '0; bus.operand_b = '0;
    bus.write_pointer = '0; bus.read_pointer = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.instruction_word !== '0 || bus.read_valid !== 1'b0 || bus.count !== '0 || bus.parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: word=%h valid=%b count=%0d perr=%b, required all zero",
               bus.instruction_word, bus.read_valid, bus.count, bus.parity_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_arith();
    step(1, 4'(ADD), 5, -3, 1, 0);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    step(1, 4'(MULT), -4, 7, 2, 1);
    exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
    checks++;
    if (bus.instruction_word.result !== 64'sd2 || bus.instruction_word.div0 !== 1'b0 || bus.read_valid !== 1'b1) begin
      failures++;
      $display("FAIL arith_add: result=%0d div0=%b valid=%b, required 2/0/1",
               bus.instruction_word.result, bus.instruction_word.div0, bus.read_valid);
    end
    step(0, 4'(ZERO), 0, 0, 0, 2);
    exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
    checks++;
    if (bus.instruction_word.result !== -64'sd28 || bus.instruction_word.div0 !== 1'b0 || bus.read_valid !== 1'b1) begin
      failures++;
      $display("FAIL arith_mult: result=%0d div0=%b valid=%b, required -28/0/1",
               bus.instruction_word.result, bus.instruction_word.div0, bus.read_valid);
    end
    got_w = bus.instruction_word;
    checks++;
    if (got_w !== exp_w) begin
      failures++;
      $display("FAIL arith_word: got %h required %h", got_w, exp_w);
    end
    checks++;
    if (bus.count !== (PTR_W+1)'(model_count())) begin
      failures++;
      $display("FAIL arith_count: got %0d required %0d", bus.count, model_count());
    end
  endtask

  task automatic test_div0();
    step(1, 4'(DIV), 9, 0, 4, 0);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    step(1, 4'(MOD), -7, 0, 5, 4);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.instruction_word.result !== 64'sd0 || bus.instruction_word.div0 !== 1'b1) begin
      failures++;
      $display("FAIL div_by_zero: result=%0d div0=%b, required 0/1",
               bus.instruction_word.result, bus.instruction_word.div0);
    end
    step(1, 4'(MOD), -7, 2, 6, 5);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.instruction_word.result !== 64'sd0 || bus.instruction_word.div0 !== 1'b1) begin
      failures++;
      $display("FAIL mod_by_zero: result=%0d div0=%b, required 0/1",
               bus.instruction_word.result, bus.instruction_word.div0);
    end
    step(0, 4'(ZERO), 0, 0, 0, 6);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.instruction_word.result !== -64'sd1 || bus.instruction_word.div0 !== 1'b0 || bus.read_valid !== 1'b1) begin
      failures++;
      $display("FAIL mod_sign: result=%0d div0=%b valid=%b, required -1/0/1",
               bus.instruction_word.result, bus.instruction_word.div0, bus.read_valid);
    end
  endtask

  task automatic test_bypass();
    step(1, 4'(SUB), 10, 4, 3, 3);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.instruction_word.result !== 64'sd6 || bus.read_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
      failures++;
      $display("FAIL bypass: result=%0d valid=%b perr=%b, required 6/1/0",
               bus.instruction_word.result, bus.read_valid, bus.parity_err);
    end
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 4'(ADD), i, 100, i, 0);
      void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    end
    // Reset mid-cycle; hold a write strobe through the reset edge.
    #2;
    bus.load_en = 1'b1;
    bus.write_pointer = '0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.instruction_word !== '0 || bus.count !== '0 || bus.read_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: word=%h count=%0d valid=%b, required zero",
               bus.instruction_word, bus.count, bus.read_valid);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (bus.count !== '0) begin
      failures++;
      $display("FAIL reset_edge_write: count=%0d required 0", bus.count);
    end
    @(negedge clk);
    bus.load_en = 1'b0;
    reset_n = 1'b1;
    step(0, 4'(ZERO), 0, 0, 0, 0);
    exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
    checks++;
    if (bus.read_valid !== 1'b0 || bus.instruction_word !== '0) begin
      failures++;
      $display("FAIL post_reset_read: valid=%b word=%h, required 0/0", bus.read_valid, bus.instruction_word);
    end
  endtask

`ifdef INSTR_REGISTER_PARITY_EN
  task automatic test_parity();
    step(1, 4'(ADD), 1, 2, 7, 0);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    step(1, 4'(SUB), 8, 3, 8, 0);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    @(negedge clk);
    dut.r_mem[7] = dut.r_mem[7] ^ W'(1);
    step(0, 4'(ZERO), 0, 0, 0, 7);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_detect: perr=%b required 1", bus.parity_err);
    end
    step(0, 4'(ZERO), 0, 0, 0, 8);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
    checks++;
    if (bus.parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean: perr=%b required 0", bus.parity_err);
    end
    // Repair the corrupted entry so later model comparisons hold.
    step(1, 4'(ADD), 1, 2, 7, 7);
    void'(exp_q.pop_front()); void'(exp_v_q.pop_front());
  endtask
`endif

  task automatic test_random();
    int wp;
    int rp;
    for (int n = 0; n < 300; n++) begin
      wp = $urandom_range(0, DEPTH-1);
      rp = ($urandom_range(0, 3) == 0) ? wp : int'($urandom_range(0, DEPTH-1));
      step(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), wp, rp);
      exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
      got_w = bus.instruction_word;
      checks++;
      if (got_w !== exp_w) begin
        failures++;
        $display("FAIL rand_word[%0d]: got %h required %h", n, got_w, exp_w);
      end
      checks++;
      if (bus.read_valid !== exp_v) begin
        failures++;
        $display("FAIL rand_valid[%0d]: got %b required %b", n, bus.read_valid, exp_v);
      end
      checks++;
      if (bus.count !== (PTR_W+1)'(model_count())) begin
        failures++;
        $display("FAIL rand_count[%0d]: got %0d required %0d", n, bus.count, model_count());
      end
      checks++;
      if (bus.parity_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_parity[%0d]: got %b required 0", n, bus.parity_err);
      end
    end
  endtask

  task automatic test_back_to_back_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 4'($urandom_range(0, 7)), rand_operand(), rand_operand(), i, (i + 1) % DEPTH);
      exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
      got_w = bus.instruction_word;
      checks++;
      if (got_w !== exp_w || bus.read_valid !== exp_v) begin
        failures++;
        $display("FAIL fill_read[%0d]: got %h/%b required %h/%b", i, got_w, bus.read_valid, exp_w, exp_v);
      end
    end
    checks++;
    if (bus.count !== (PTR_W+1)'(DEPTH)) begin
      failures++;
      $display("FAIL count_full: got %0d required %0d", bus.count, DEPTH);
    end
    step(1, 4'(PASSA), -1, 0, 0, 0);
    exp_w = exp_q.pop_front(); exp_v = exp_v_q.pop_front();
    checks++;
    if (bus.count !== (PTR_W+1)'(DEPTH)) begin
      failures++;
      $display("FAIL count_overwrite: got %0d required %0d", bus.count, DEPTH);
    end
    checks++;
    if (bus.instruction_word.result !== -64'sd1) begin
      failures++;
      $display("FAIL passa_signext: got %0d required -1", bus.instruction_word.result);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arith();
    test_div0();
    test_bypass();
    test_midrun_reset();
`ifdef INSTR_REGISTER_PARITY_EN
    test_parity();
`endif
    test_random();
    test_back_to_back_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
